// File: rtl/axi_lite_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_rr_arbiter
// Shares one AXI4-Lite slave port between N_M AXI4-Lite masters. Arbitration
// is round-robin per whole transaction (read = AR+R, write = AW+W+B), with
// one transaction outstanding at a time.
//
// Ports
//   aclk, areset_n        clock, asynchronous active-low reset
//   s_ar*/s_r*            per-master read channels (valid/ready per master,
//                         rdata/rresp broadcast)
//   s_aw*/s_w*/s_b*       per-master write channels (bresp broadcast)
//   m_*                   single slave-side AXI4-Lite port
//   grant                 one-hot owner of the current transaction, 0 in IDLE
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a response that does not arrive within TMO_CYC cycles is
//   answered locally with SLVERR (RERR/BERR states); a late response from the
//   slave is dropped. When undefined the arbiter waits forever.
// ---------------------------------------------------------------------------
module axi_lite_rr_arbiter #(
  parameter int N_M     = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 64
) (
  input  logic                       aclk,
  input  logic                       areset_n,
  input  logic [N_M-1:0]             s_arvalid,
  input  logic [N_M*ADDR_W-1:0]      s_araddr,
  output logic [N_M-1:0]             s_arready,
  output logic [N_M-1:0]             s_rvalid,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [1:0]                 s_rresp,
  input  logic [N_M-1:0]             s_rready,
  input  logic [N_M-1:0]             s_awvalid,
  input  logic [N_M*ADDR_W-1:0]      s_awaddr,
  output logic [N_M-1:0]             s_awready,
  input  logic [N_M-1:0]             s_wvalid,
  input  logic [N_M*DATA_W-1:0]      s_wdata,
  input  logic [N_M*DATA_W/8-1:0]    s_wstrb,
  output logic [N_M-1:0]             s_wready,
  output logic [N_M-1:0]             s_bvalid,
  output logic [1:0]                 s_bresp,
  input  logic [N_M-1:0]             s_bready,
  output logic                       m_arvalid,
  output logic [ADDR_W-1:0]          m_araddr,
  input  logic                       m_arready,
  input  logic                       m_rvalid,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic [1:0]                 m_rresp,
  output logic                       m_rready,
  output logic                       m_awvalid,
  output logic [ADDR_W-1:0]          m_awaddr,
  input  logic                       m_awready,
  output logic                       m_wvalid,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic                       m_wready,
  input  logic                       m_bvalid,
  input  logic [1:0]                 m_bresp,
  output logic                       m_bready,
  output logic [N_M-1:0]             grant
);

  localparam int IW = (N_M > 1) ? $clog2(N_M) : 1;
  localparam int SW = DATA_W / 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RADDR = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WADDR = 3'd3;
  localparam logic [2:0] ST_WDATA = 3'd4;
  localparam logic [2:0] ST_WRESP = 3'd5;
`ifdef ARB_TIMEOUT_EN
  localparam logic [2:0] ST_RERR  = 3'd6;
  localparam logic [2:0] ST_BERR  = 3'd7;
  localparam int         TW       = $clog2(TMO_CYC + 1);
  logic [TW-1:0]         r_tmo;
`endif

  logic [2:0]     r_state;
  logic [N_M-1:0] r_grant;
  // Round-robin pointer; once a grant is made it also names the owner.
  logic [IW-1:0]  r_ptr;
  logic [N_M-1:0] w_req;
  logic           w_found;
  logic [IW-1:0]  w_win;
  logic [IW-1:0]  w_cand;

  assign w_req = s_arvalid | s_awvalid;
  assign grant = r_grant;

  // Round-robin search: first requester strictly after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_M; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % N_M);
      if (!w_found && w_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Transaction state machine, grant register and round-robin pointer.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= IW'(N_M - 1);
`ifdef ARB_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= {{(N_M-1){1'b0}}, 1'b1} << w_win;
            r_ptr   <= w_win;
            // A master asking for both is served its read first.
            r_state <= s_arvalid[w_win] ? ST_RADDR : ST_WADDR;
          end
        end
        ST_RADDR: begin
          if (s_arvalid[r_ptr] && m_arready) begin
            r_state <= ST_RDATA;
`ifdef ARB_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end
        end
        ST_RDATA: begin
          if (m_rvalid && s_rready[r_ptr]) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (!m_rvalid) begin
            if (r_tmo == TW'(TMO_CYC - 1)) begin
              r_state <= ST_RERR;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
`endif
        end
        ST_WADDR: begin
          if (s_awvalid[r_ptr] && m_awready) begin
            r_state <= ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (s_wvalid[r_ptr] && m_wready) begin
            r_state <= ST_WRESP;
`ifdef ARB_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end
        end
        ST_WRESP: begin
          if (m_bvalid && s_bready[r_ptr]) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (!m_bvalid) begin
            if (r_tmo == TW'(TMO_CYC - 1)) begin
              r_state <= ST_BERR;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
`endif
        end
`ifdef ARB_TIMEOUT_EN
        ST_RERR: begin
          if (s_rready[r_ptr]) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
        end
        ST_BERR: begin
          if (s_bready[r_ptr]) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Channel routing: only the owner's channel in the current state is
  // connected; every other valid/ready/data/resp is held at 0.
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = 2'b00;
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_bready  = 1'b0;
    case (r_state)
      ST_RADDR: begin
        m_arvalid        = s_arvalid[r_ptr];
        m_araddr         = s_araddr[r_ptr*ADDR_W +: ADDR_W];
        s_arready[r_ptr] = m_arready;
      end
      ST_RDATA: begin
        s_rvalid[r_ptr] = m_rvalid;
        s_rdata         = m_rdata;
        s_rresp         = m_rresp;
        m_rready        = s_rready[r_ptr];
      end
      ST_WADDR: begin
        m_awvalid        = s_awvalid[r_ptr];
        m_awaddr         = s_awaddr[r_ptr*ADDR_W +: ADDR_W];
        s_awready[r_ptr] = m_awready;
      end
      ST_WDATA: begin
        m_wvalid        = s_wvalid[r_ptr];
        m_wdata         = s_wdata[r_ptr*DATA_W +: DATA_W];
        m_wstrb         = s_wstrb[r_ptr*SW +: SW];
        s_wready[r_ptr] = m_wready;
      end
      ST_WRESP: begin
        s_bvalid[r_ptr] = m_bvalid;
        s_bresp         = m_bresp;
        m_bready        = s_bready[r_ptr];
      end
`ifdef ARB_TIMEOUT_EN
      // Local SLVERR; the slave's response channel stays disconnected.
      ST_RERR: begin
        s_rvalid[r_ptr] = 1'b1;
        s_rresp         = 2'b10;
      end
      ST_BERR: begin
        s_bvalid[r_ptr] = 1'b1;
        s_bresp         = 2'b10;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_rr_arbiter
// Directed bench for axi_lite_rr_arbiter (N_M=2, ADDR_W=12, DATA_W=32).
// Inputs change #1 after the rising edge or on the falling edge; outputs are
// checked on the falling edge (or #1 after an input change there).
// The timeout scenario is compiled only when ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_axi_lite_rr_arbiter;
  localparam int N_M = 2;
  localparam int AW  = 12;
  localparam int DW  = 32;

  logic              aclk = 1'b0;
  logic              areset_n;
  logic [N_M-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N_M*AW-1:0] s_araddr, s_awaddr;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp, s_bresp;
  logic [N_M-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N_M*DW-1:0] s_wdata;
  logic [N_M*DW/8-1:0] s_wstrb;
  logic              m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]     m_araddr, m_awaddr;
  logic [DW-1:0]     m_rdata, m_wdata;
  logic [1:0]        m_rresp, m_bresp;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DW/8-1:0]   m_wstrb;
  logic [N_M-1:0]    grant;

  int n_chk  = 0;
  int n_fail = 0;

  axi_lite_rr_arbiter #(.N_M(N_M), .ADDR_W(AW), .DATA_W(DW), .TMO_CYC(64)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .grant(grant)
  );

  // 100 MHz clock.
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    s_arvalid = '0; s_araddr = '0; s_rready = '0;
    s_awvalid = '0; s_awaddr = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0;
    s_bready  = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset_n = 1'b1;
    s_rready = '1;
    s_bready = '1;
    @(posedge aclk); #1;
  endtask

  // Slave side of one read: waits for m_arvalid, accepts AR, returns data.
  task automatic slave_read(input int m, input logic [AW-1:0] exp_addr,
                            input logic [N_M-1:0] exp_grant, input logic [DW-1:0] data,
                            input logic [1:0] resp, input bit drop, output int waited);
    int n = 0;
    @(negedge aclk);
    while (m_arvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    waited = n;
    chk("ar_wait", 64'(n < 20), 64'd1);
    chk("ar_grant", 64'(grant), 64'(exp_grant));
    chk("ar_addr", 64'(m_araddr), 64'(exp_addr));
    chk("ar_no_aw", 64'(m_awvalid), 64'd0);
    m_arready = 1'b1;
    #1;
    chk("ar_ready_route", 64'(s_arready), 64'(exp_grant));
    @(posedge aclk); #1;
    m_arready = 1'b0;
    if (drop) s_arvalid[m] = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = data;
    m_rresp  = resp;
    @(negedge aclk);
    chk("r_valid_route", 64'(s_rvalid), 64'(exp_grant));
    chk("r_data", 64'(s_rdata), 64'(data));
    chk("r_resp", 64'(s_rresp), 64'(resp));
    chk("r_m_rready", 64'(m_rready), 64'd1);
    @(posedge aclk); #1;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_rresp  = 2'b00;
  endtask

  // Slave side of one write: AW, then W, then B; master drops its valids.
  task automatic slave_write(input int m, input logic [AW-1:0] exp_addr,
                             input logic [N_M-1:0] exp_grant, input logic [DW-1:0] exp_data,
                             input logic [3:0] exp_strb, input logic [1:0] resp);
    int n = 0;
    @(negedge aclk);
    while (m_awvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("aw_wait", 64'(n < 20), 64'd1);
    chk("aw_grant", 64'(grant), 64'(exp_grant));
    chk("aw_addr", 64'(m_awaddr), 64'(exp_addr));
    chk("aw_no_ar", 64'(m_arvalid), 64'd0);
    chk("aw_no_w", 64'(m_wvalid), 64'd0);
    m_awready = 1'b1;
    #1;
    chk("aw_ready_route", 64'(s_awready), 64'(exp_grant));
    @(posedge aclk); #1;
    m_awready = 1'b0;
    s_awvalid[m] = 1'b0;
    @(negedge aclk);
    chk("w_valid", 64'(m_wvalid), 64'd1);
    chk("w_data", 64'(m_wdata), 64'(exp_data));
    chk("w_strb", 64'(m_wstrb), 64'(exp_strb));
    chk("w_no_aw", 64'(m_awvalid), 64'd0);
    m_wready = 1'b1;
    #1;
    chk("w_ready_route", 64'(s_wready), 64'(exp_grant));
    @(posedge aclk); #1;
    m_wready = 1'b0;
    s_wvalid[m] = 1'b0;
    m_bvalid = 1'b1;
    m_bresp  = resp;
    @(negedge aclk);
    chk("b_valid_route", 64'(s_bvalid), 64'(exp_grant));
    chk("b_resp", 64'(s_bresp), 64'(resp));
    chk("b_m_bready", 64'(m_bready), 64'd1);
    @(posedge aclk); #1;
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // ---- Reset state, with busy-looking inputs driven ----
    areset_n = 1'b0;
    clear_inputs();
    s_arvalid = 2'b11;
    m_rdata   = 32'hFFFF_FFFF;
    m_rvalid  = 1'b1;
    s_araddr  = {12'h0FF, 12'h0EE};
    repeat (2) @(negedge aclk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_m_araddr", 64'(m_araddr), 64'd0);
    chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_s_rdata", 64'(s_rdata), 64'd0);
    chk("rst_s_arready", 64'(s_arready), 64'd0);
    chk("rst_m_wvalid", 64'(m_wvalid), 64'd0);
    do_reset();

    // ---- 1: M0 reads 0x004, slave returns 0xA5 OKAY ----
    s_araddr[0*AW +: AW] = 12'h004;
    s_arvalid[0] = 1'b1;
    @(negedge aclk);
    chk("t1_idle_grant", 64'(grant), 64'd0);
    chk("t1_idle_arvalid", 64'(m_arvalid), 64'd0);
    @(posedge aclk); #1;
    slave_read(0, 12'h004, 2'b01, 32'h0000_00A5, 2'b00, 1'b1, w);
    chk("t1_latency", 64'(w), 64'd0);
    @(negedge aclk);
    chk("t1_back_idle", 64'(grant), 64'd0);

    // ---- 2: both masters read continuously -> 01,10,01,10 ----
    do_reset();
    s_araddr  = {12'h200, 12'h100};
    s_arvalid = 2'b11;
    slave_read(0, 12'h100, 2'b01, 32'h1111_0000, 2'b00, 1'b0, w);
    slave_read(1, 12'h200, 2'b10, 32'h2222_0000, 2'b00, 1'b0, w);
    slave_read(0, 12'h100, 2'b01, 32'h1111_0001, 2'b00, 1'b0, w);
    slave_read(1, 12'h200, 2'b10, 32'h2222_0001, 2'b01, 1'b0, w);
    s_arvalid = 2'b00;

    // ---- 3: same cycle M0 writes 0x008/0x55, M1 reads 0x00C ----
    do_reset();
    s_awaddr[0*AW +: AW] = 12'h008;
    s_wdata[0*DW +: DW]  = 32'h0000_0055;
    s_wstrb[0*4 +: 4]    = 4'hF;
    s_araddr[1*AW +: AW] = 12'h00C;
    s_awvalid[0] = 1'b1;
    s_wvalid[0]  = 1'b1;
    s_arvalid[1] = 1'b1;
    slave_write(0, 12'h008, 2'b01, 32'h0000_0055, 4'hF, 2'b00);
    slave_read(1, 12'h00C, 2'b10, 32'h0000_0C0C, 2'b00, 1'b1, w);

    // ---- 4: M1 holds arvalid and awvalid -> read first, then write ----
    do_reset();
    s_araddr[1*AW +: AW] = 12'h010;
    s_awaddr[1*AW +: AW] = 12'h014;
    s_wdata[1*DW +: DW]  = 32'hDEAD_BEEF;
    s_wstrb[1*4 +: 4]    = 4'h3;
    s_arvalid[1] = 1'b1;
    s_awvalid[1] = 1'b1;
    s_wvalid[1]  = 1'b1;
    slave_read(1, 12'h010, 2'b10, 32'h0101_0101, 2'b00, 1'b1, w);
    slave_write(1, 12'h014, 2'b10, 32'hDEAD_BEEF, 4'h3, 2'b10);

    // ---- 5: reset during WDATA; M0 wins first afterwards ----
    do_reset();
    s_awaddr[0*AW +: AW] = 12'h020;
    s_wdata[0*DW +: DW]  = 32'h0000_1234;
    s_wstrb[0*4 +: 4]    = 4'hF;
    s_awvalid[0] = 1'b1;
    s_wvalid[0]  = 1'b1;
    begin
      int n = 0;
      @(negedge aclk);
      while (m_awvalid !== 1'b1 && n < 20) begin
        @(negedge aclk);
        n++;
      end
      chk("t5_aw_wait", 64'(n < 20), 64'd1);
    end
    m_awready = 1'b1;
    @(posedge aclk); #1;
    m_awready = 1'b0;
    @(negedge aclk);
    chk("t5_in_wdata", 64'(m_wvalid), 64'd1);
    chk("t5_grant_wdata", 64'(grant), 64'd1);
    s_araddr  = {12'h040, 12'h030};
    s_arvalid = 2'b11;
    m_wready  = 1'b1;
    #1;
    areset_n = 1'b0;
    #1;
    chk("t5_rst_grant", 64'(grant), 64'd0);
    chk("t5_rst_wvalid", 64'(m_wvalid), 64'd0);
    chk("t5_rst_wdata", 64'(m_wdata), 64'd0);
    chk("t5_rst_wready", 64'(s_wready), 64'd0);
    chk("t5_rst_wstrb", 64'(m_wstrb), 64'd0);
    m_wready  = 1'b0;
    s_awvalid = '0;
    s_wvalid  = '0;
    @(posedge aclk);
    @(negedge aclk);
    areset_n = 1'b1;
    slave_read(0, 12'h030, 2'b01, 32'h3030_3030, 2'b00, 1'b1, w);
    slave_read(1, 12'h040, 2'b10, 32'h4040_4040, 2'b00, 1'b1, w);

`ifdef ARB_TIMEOUT_EN
    // ---- 6: slave never answers the read -> local SLVERR after 64 cycles ----
    do_reset();
    s_araddr[0*AW +: AW] = 12'h050;
    s_arvalid[0] = 1'b1;
    s_rready     = 2'b00;
    begin
      int n = 0;
      @(negedge aclk);
      while (m_arvalid !== 1'b1 && n < 20) begin
        @(negedge aclk);
        n++;
      end
      chk("t6_ar_wait", 64'(n < 20), 64'd1);
    end
    m_arready = 1'b1;
    @(posedge aclk); #1;
    m_arready    = 1'b0;
    s_arvalid[0] = 1'b0;
    m_rdata      = 32'h0000_CAFE;
    begin
      int n = 0;
      while (s_rvalid === 2'b00 && n < 200) begin
        @(posedge aclk); #1;
        n++;
      end
      chk("t6_tmo_cycles", 64'(n), 64'd64);
    end
    @(negedge aclk);
    chk("t6_rvalid", 64'(s_rvalid), 64'd1);
    chk("t6_rresp", 64'(s_rresp), 64'd2);
    chk("t6_rdata", 64'(s_rdata), 64'd0);
    chk("t6_m_rready", 64'(m_rready), 64'd0);
    s_rready = 2'b11;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("t6_idle", 64'(grant), 64'd0);
    chk("t6_rvalid_off", 64'(s_rvalid), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
